led_ring_driver: RTL and testbench
==================================

// Module: led_ring_driver
// PURPOSE
//  Serial transmitter for the display-board WS2812-style LED pixel ring on LEDRINGn. It is the output-direction
//  counterpart of shiftregctl, which reads the button chain. On start it fetches NUM_LEDS 24-bit pixels from a
//  1-cycle-latency pixel store, scales them by a global brightness and emits the one-wire NRZ bit stream.
//  It then holds the line idle for the latch period and pulses done. The board inverts the signal, so the
//  output is active-low.
// PARAMETERS
//  NUM_LEDS      16    pixels per frame
//  BIT_CYCLES    63    clk cycles per bit (1.26us @ 50MHz)
//  T0H_CYCLES    20    ring-side high time for a 0 bit
//  T1H_CYCLES    40    ring-side high time for a 1 bit
//  RESET_CYCLES  3000  ring-side low time for the latch/reset gap (60us)
// PORTS
//  clk         in   1                  50MHz system clock (CLOCK_50)
//  rst         in   1                  synchronous, active-high reset
//  start       in   1                  request one frame; sampled only in IDLE
//  brightness  in   8                  global scale, sampled at each pixel load
//  pix_rd      out  1                  one-cycle read strobe to the pixel store
//  pix_idx     out  $clog2(NUM_LEDS)   pixel address, valid while pix_rd=1
//  pix_rgb     in   24                 {R,G,B}; valid the cycle after pix_rd
//  led_ring_n  out  1                  serial data to LEDRINGn; 1 = ring-side low
//  busy        out  1                  high in every state except IDLE
//  done        out  1                  one-cycle pulse when the latch gap completes after a full frame
// BEHAVIOUR
//  Reset values
//  - state=LATCH, latch counter=0, led_ring_n=1, busy=1, done=0, pix_rd=0, pix_idx=0.
//  - After RESET_CYCLES the block enters IDLE with busy=0 and no done pulse. This terminates any partial frame.
//  States: IDLE, FETCH, LOAD, SEND, LATCH.
//  - IDLE: start=1 moves to FETCH. In all other states start is ignored, never queued.
//  - FETCH (1 cycle): pix_rd=1, pix_idx=0.
//  - LOAD (1 cycle): latch the scaled pix_rgb into the shift register.
//  - SEND: the first bit begins the next cycle, so start-to-first-led_ring_n-fall latency is 3 cycles.
//  Bit timing
//  - bit_cnt runs 0..BIT_CYCLES-1.
//  - led_ring_n=0 while bit_cnt < (bit ? T1H_CYCLES : T0H_CYCLES), else 1.
//  - Bits are sent in GRB order, MSB first: G[7]..G[0], R[7]..R[0], B[7]..B[0].
//  Prefetch for pixel p (p < NUM_LEDS-1)
//  - At bit 0 / bit_cnt==0: pix_rd=1 and pix_idx=p+1.
//  - At bit_cnt==1: pix_rgb is captured, scaled and stored in the next-pixel buffer.
//  - At the end of bit 23 the buffer moves to the shift register with no gap. The stream is continuous for
//    NUM_LEDS*24*BIT_CYCLES cycles.
//  - For the last pixel pix_rd is not asserted. Exactly NUM_LEDS pix_rd pulses occur per frame, spaced
//    24*BIT_CYCLES apart.
//  Frame end
//  - After the last bit: LATCH with led_ring_n=1 for RESET_CYCLES.
//  - On the final LATCH cycle: done=1. The next cycle is IDLE, busy=0.
//  - A start asserted on the IDLE cycle right after done begins a new frame.
//  Scaling (per channel)
//  - out = (ch * (brightness+1)) >> 8, with a 16-bit intermediate and an 8-bit result.
//  - brightness=255 is identity; brightness=0 gives 0.
//  Reset mid-operation
//  - Any state returns to the reset values on the next edge: led_ring_n=1 and LATCH restarts.
//  - No done pulse for an aborted frame.
//  Other rules
//  - pix_rgb is ignored except in the capture cycles above.
//  - No combinational path from inputs to outputs. All outputs are registered.
// STRUCTURE
//  Package led_ring_pkg
//  - typedef struct packed {logic [7:0] r,g,b;} rgb_t
//  - typedef enum {IDLE,FETCH,LOAD,SEND,LATCH} ledring_state_t
//  - 50MHz default timing constants
//  Sub-module led_bright_scale
//  - Combinational: rgb_t in, 8-bit brightness -> rgb_t out.
//  - Instantiated once on the pix_rgb path.
// TESTING
//  1. Reset: rst held 1 cycle -> led_ring_n=1, busy=1 for 3000 cycles, then busy=0, done never pulses.
//  2. NUM_LEDS=2, both pixels 0xFF0000, brightness=255, start pulse:
//     - First led_ring_n fall 3 cycles after start.
//     - Low (ring-high) widths: 8x20, 8x40, 8x20 per pixel, period 63.
//     - done exactly once, 3000 cycles after the last bit.
//  3. Brightness, pixel 0x80FF01:
//     - brightness=127 -> transmitted GRB 0x7F4000.
//     - brightness=0 -> all bits 20-cycle lows.
//  4. pix_rd cadence, NUM_LEDS=16:
//     - 16 pulses with pix_idx 0..15.
//     - Pulses 2..16 spaced 1512 cycles apart.
//     - Store returns idx*0x111111; decoded stream matches per pixel.
//  5. start pulsed mid-SEND and during LATCH -> ignored: single frame, single done.
//  6. rst asserted at pixel 1, bit 5 -> led_ring_n=1 next cycle, busy stays 1, no done; a subsequent start
//     after busy=0 sends a complete, correct frame.

Source files
------------

// File: rtl/led_ring_pkg.sv
// Shared types, default 50 MHz timing and the brightness helper for the
// LED pixel-ring transmitter.
//   rgb_t           : one pixel as stored, {R,G,B}
//   ledring_state_t : transmitter states
//   scale_channel   : out = (ch * (level+1)) >> 8, 255 is identity, 0 blanks
//   grb_order       : reorders a stored pixel into the ring's wire order
package led_ring_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, LATCH} ledring_state_t;

  localparam int DEF_NUM_LEDS     = 16;
  localparam int DEF_BIT_CYCLES   = 63;    // 1.26 us at 50 MHz
  localparam int DEF_T0H_CYCLES   = 20;
  localparam int DEF_T1H_CYCLES   = 40;
  localparam int DEF_RESET_CYCLES = 3000;  // 60 us latch gap
  localparam int BITS_PER_PIXEL   = 24;

  function automatic logic [7:0] scale_channel(input logic [7:0] ch, input logic [7:0] level);
    logic [15:0] prod;
    prod = 16'(ch) * (16'(level) + 16'd1);
    return prod[15:8];
  endfunction

  function automatic logic [23:0] grb_order(input rgb_t px);
    return {px.g, px.r, px.b};
  endfunction

endpackage

// File: rtl/led_ring_driver_scale.sv
// Combinational global-brightness scaler for one pixel.
//   rgb        : pixel from the store, {R,G,B}
//   brightness : global level, 255 passes the pixel unchanged
//   scaled     : scaled pixel, {R,G,B}
module led_bright_scale
  import led_ring_pkg::*;
(
  input  rgb_t       rgb,
  input  logic [7:0] brightness,
  output rgb_t       scaled
);

  // NOTE: every field is assigned on every evaluation, so no latch is inferred.
  always_comb begin
    scaled.r = scale_channel(rgb.r, brightness);
    scaled.g = scale_channel(rgb.g, brightness);
    scaled.b = scale_channel(rgb.b, brightness);
  end

endmodule

// File: rtl/led_ring_driver.sv
// One-wire NRZ transmitter for a WS2812-style pixel ring (active-low line,
// the board inverts it). A start fetches NUM_LEDS pixels from a store with
// one cycle of read latency, scales them, streams them GRB/MSB-first with no
// inter-pixel gap, then holds the latch gap and pulses done.
//   clk, rst   : clock and synchronous active-high reset
//   start      : frame request, honoured only in IDLE
//   brightness : global scale, sampled whenever a pixel is captured
//   pix_rd     : one-cycle read strobe, pix_idx is the address
//   pix_rgb    : store data, valid the cycle after pix_rd
//   led_ring_n : serial line, 1 = ring-side low
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse on the last latch cycle of a complete frame
module led_ring_driver
  import led_ring_pkg::*;
#(
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  brightness,
  output logic                        pix_rd,
  output logic [$clog2(NUM_LEDS)-1:0] pix_idx,
  input  logic [23:0]                 pix_rgb,
  output logic                        led_ring_n,
  output logic                        busy,
  output logic                        done
);

  localparam int IDX_W = $clog2(NUM_LEDS);
  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam int LAT_W = $clog2(RESET_CYCLES);

  localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T0H          = CNT_W'(T0H_CYCLES);
  localparam logic [CNT_W-1:0] T1H          = CNT_W'(T1H_CYCLES);
  localparam logic [4:0]       BIT_IDX_LAST = 5'(BITS_PER_PIXEL - 1);
  localparam logic [IDX_W-1:0] PIX_LAST     = IDX_W'(NUM_LEDS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST     = LAT_W'(RESET_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_DONE     = LAT_W'(RESET_CYCLES - 2);

  ledring_state_t   state;
  logic [CNT_W-1:0] bit_cnt;
  logic [4:0]       bit_idx;
  logic [IDX_W-1:0] pix_cnt;
  logic [LAT_W-1:0] latch_cnt;
  logic [23:0]      shift_reg;
  logic [23:0]      next_buf;
  logic             frame_ok;   // latch gap follows a complete frame
  rgb_t             scaled;
  logic [CNT_W-1:0] high_len;

  led_bright_scale u_scale (
    .rgb       (pix_rgb),
    .brightness(brightness),
    .scaled    (scaled)
  );

  assign high_len = shift_reg[23] ? T1H : T0H;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LATCH;
      latch_cnt  <= '0;
      led_ring_n <= 1'b1;
      busy       <= 1'b1;
      done       <= 1'b0;
      pix_rd     <= 1'b0;
      pix_idx    <= '0;
      frame_ok   <= 1'b0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      pix_cnt    <= '0;
      // NOTE: shift_reg and next_buf are pure datapath, always written
      // before they are used, so they carry no reset.
    end else begin
      pix_rd <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          led_ring_n <= 1'b1;
          if (start) begin
            state   <= FETCH;
            busy    <= 1'b1;
            pix_rd  <= 1'b1;
            pix_idx <= '0;
          end
        end

        FETCH: state <= LOAD;

        LOAD: begin
          shift_reg <= grb_order(scaled);
          state     <= SEND;
          bit_cnt   <= '0;
          bit_idx   <= '0;
          pix_cnt   <= '0;
          // Prefetch for pixel 1 is issued on pixel 0's first bit cycle.
          pix_rd    <= 1'b1;
          pix_idx   <= IDX_W'(1);
        end

        SEND: begin
          // The line is driven from the previous cycle's counter, which puts
          // the first fall three cycles after start.
          led_ring_n <= (bit_cnt >= high_len);
          if (bit_cnt == CNT_W'(1) && bit_idx == 5'd0 && pix_cnt != PIX_LAST)
            next_buf <= grb_order(scaled);
          if (bit_cnt != BIT_LAST) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end else begin
            bit_cnt <= '0;
            if (bit_idx != BIT_IDX_LAST) begin
              bit_idx   <= bit_idx + 5'd1;
              shift_reg <= {shift_reg[22:0], 1'b0};
            end else begin
              bit_idx <= '0;
              if (pix_cnt == PIX_LAST) begin
                state     <= LATCH;
                latch_cnt <= '0;
                frame_ok  <= 1'b1;
              end else begin
                pix_cnt   <= pix_cnt + IDX_W'(1);
                shift_reg <= next_buf;
                if (pix_cnt + IDX_W'(1) != PIX_LAST) begin
                  pix_rd  <= 1'b1;
                  pix_idx <= pix_cnt + IDX_W'(2);
                end
              end
            end
          end
        end

        LATCH: begin
          led_ring_n <= 1'b1;
          if (latch_cnt == LAT_LAST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            frame_ok <= 1'b0;
          end else begin
            latch_cnt <= latch_cnt + LAT_W'(1);
            if (latch_cnt == LAT_DONE && frame_ok)
              done <= 1'b1;
          end
        end

        default: begin
          state     <= LATCH;
          latch_cnt <= '0;
          busy      <= 1'b1;
          frame_ok  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_ring_driver.sv
// Directed bench for led_ring_driver: a 2-pixel instance (a) for reset,
// timing, brightness, start-ignore and abort cases, and a 16-pixel instance
// (b) for read cadence and a full frame. The line is decoded from ring-high
// widths (20 -> 0, 40 -> 1).
module tb_led_ring_driver;

  localparam int PIX_CYC = 24 * 63;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic        rst_a, start_a, pix_rd_a, led_a, busy_a, done_a;
  logic [7:0]  bright_a;
  logic [0:0]  pix_idx_a;
  logic [23:0] pix_rgb_a;
  logic        rst_b, start_b, pix_rd_b, led_b, busy_b, done_b;
  logic [7:0]  bright_b;
  logic [3:0]  pix_idx_b;
  logic [23:0] pix_rgb_b;

  logic [23:0] mem_a [2];
  logic [23:0] mem_b [16];
  logic [23:0] exp_grb [16];

  led_ring_driver #(.NUM_LEDS(2)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .brightness(bright_a),
    .pix_rd(pix_rd_a), .pix_idx(pix_idx_a), .pix_rgb(pix_rgb_a),
    .led_ring_n(led_a), .busy(busy_a), .done(done_a));

  led_ring_driver #(.NUM_LEDS(16)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .brightness(bright_b),
    .pix_rd(pix_rd_b), .pix_idx(pix_idx_b), .pix_rgb(pix_rgb_b),
    .led_ring_n(led_b), .busy(busy_b), .done(done_b));

  // Pixel stores: one-cycle latency, junk whenever not being read.
  always @(posedge clk) pix_rgb_a <= pix_rd_a ? mem_a[pix_idx_a] : 24'($urandom);
  always @(posedge clk) pix_rgb_b <= pix_rd_b ? mem_b[pix_idx_b] : 24'($urandom);

  // Line monitors.
  int widths_a[$], falls_a[$], rd_cyc_a[$], rd_idx_a[$];
  int widths_b[$], falls_b[$], rd_cyc_b[$], rd_idx_b[$];
  int low_a = 0, low_b = 0, done_cnt_a = 0, done_cnt_b = 0, done_cyc_a = 0, done_cyc_b = 0;
  bit prev_a = 1'b1, prev_b = 1'b1;

  always @(negedge clk) begin
    if (led_a === 1'b0) begin
      if (prev_a) falls_a.push_back(cyc);
      low_a++;
    end else if (low_a > 0) begin
      widths_a.push_back(low_a);
      low_a = 0;
    end
    prev_a = (led_a !== 1'b0);
    if (done_a === 1'b1) begin done_cnt_a++; done_cyc_a = cyc; end
    if (pix_rd_a === 1'b1) begin rd_cyc_a.push_back(cyc); rd_idx_a.push_back(int'(pix_idx_a)); end
  end

  always @(negedge clk) begin
    if (led_b === 1'b0) begin
      if (prev_b) falls_b.push_back(cyc);
      low_b++;
    end else if (low_b > 0) begin
      widths_b.push_back(low_b);
      low_b = 0;
    end
    prev_b = (led_b !== 1'b0);
    if (done_b === 1'b1) begin done_cnt_b++; done_cyc_b = cyc; end
    if (pix_rd_b === 1'b1) begin rd_cyc_b.push_back(cyc); rd_idx_b.push_back(int'(pix_idx_b)); end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int start_cyc = 0;

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    start_cyc = cyc + 1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic clear_mon();
    widths_a.delete(); falls_a.delete(); rd_cyc_a.delete(); rd_idx_a.delete();
    widths_b.delete(); falls_b.delete(); rd_cyc_b.delete(); rd_idx_b.delete();
  endtask

  task automatic wait_done(input string tag, input bit sel, input int d0, input int max);
    int i = 0;
    while ((sel ? done_cnt_b : done_cnt_a) == d0 && i < max) begin
      tick();
      i++;
    end
    check($sformatf("%s_done_seen", tag), ((sel ? done_cnt_b : done_cnt_a) != d0), 1);
  endtask

  task automatic wait_busy_low(input string tag, input int max, output int t);
    int i = 0;
    while (busy_a !== 1'b0 && i < max) begin
      tick();
      i++;
    end
    check($sformatf("%s_busy_fell", tag), (busy_a === 1'b0), 1);
    t = cyc;
  endtask

  // Decodes the captured widths into GRB words and compares with exp_grb.
  task automatic check_frame(input string tag, input bit sel, input int n);
    int w[$], f[$];
    int bad_w = 0, bad_p = 0;
    logic [23:0] word;
    if (sel) begin w = widths_b; f = falls_b; end
    else     begin w = widths_a; f = falls_a; end
    check($sformatf("%s_nbits", tag), w.size(), n * 24);
    for (int p = 0; p < n; p++) begin
      word = '0;
      for (int b = 0; b < 24; b++) begin
        int k = p * 24 + b;
        if (k < w.size() && w[k] == 40)      word = {word[22:0], 1'b1};
        else if (k < w.size() && w[k] == 20) word = {word[22:0], 1'b0};
        else bad_w++;
      end
      check($sformatf("%s_pix%0d", tag, p), word, exp_grb[p]);
    end
    check($sformatf("%s_bad_widths", tag), bad_w, 0);
    for (int i = 1; i < f.size(); i++)
      if (f[i] - f[i-1] != 63) bad_p++;
    check($sformatf("%s_bit_period", tag), bad_p, 0);
  endtask

  task automatic run_full(input string tag, input bit sel, input int n);
    int d0, first;
    clear_mon();
    d0 = sel ? done_cnt_b : done_cnt_a;
    pulse_start(sel);
    wait_done(tag, sel, d0, n * PIX_CYC + 3100);
    first = sel ? (falls_b.size() > 0 ? falls_b[0] : -1) : (falls_a.size() > 0 ? falls_a[0] : -1);
    check($sformatf("%s_first_fall", tag), first - start_cyc, 3);
    check_frame(tag, sel, n);
    // Last bit ends start+2+n*1512; done sits on the 3000th latch cycle.
    check($sformatf("%s_done_lat", tag), (sel ? done_cyc_b : done_cyc_a) - start_cyc, n * PIX_CYC + 3001);
    check($sformatf("%s_done_cnt", tag), (sel ? done_cnt_b : done_cnt_a), d0 + 1);
    tick();
    check($sformatf("%s_idle", tag), (sel ? busy_b : busy_a), 1'b0);
  endtask

  initial begin
    int t, e, s0, d0, bad;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    bright_a = 8'd255; bright_b = 8'd255;

    // 1. Reset for one cycle, then the latch gap, no done.
    tick();
    rst_a = 1'b0; rst_b = 1'b0;
    e = cyc;
    check("rst_led", led_a, 1'b1);
    check("rst_busy", busy_a, 1'b1);
    check("rst_done", done_a, 1'b0);
    check("rst_pix_rd", pix_rd_a, 1'b0);
    check("rst_pix_idx", pix_idx_a, 1'b0);
    wait_busy_low("rst", 3100, t);
    check("rst_busy_len", t - e, 3000);
    check("rst_no_done", done_cnt_a, 0);

    // 2. Red pixels at full brightness: GRB 00 FF 00.
    mem_a[0] = 24'hFF0000; mem_a[1] = 24'hFF0000;
    exp_grb[0] = 24'h00FF00; exp_grb[1] = 24'h00FF00;
    run_full("red", 1'b0, 2);
    check("red_rd_cnt", rd_cyc_a.size(), 2);

    // 3. Brightness scaling of 0x80FF01.
    mem_a[0] = 24'h80FF01; mem_a[1] = 24'h80FF01;
    bright_a = 8'd127;
    exp_grb[0] = 24'h7F4000; exp_grb[1] = 24'h7F4000;
    run_full("b127", 1'b0, 2);
    bright_a = 8'd0;
    exp_grb[0] = 24'h000000; exp_grb[1] = 24'h000000;
    run_full("b0", 1'b0, 2);

    // 5. start during SEND and LATCH is ignored.
    bright_a = 8'd255;
    mem_a[0] = 24'hFF0000; mem_a[1] = 24'hFF0000;
    exp_grb[0] = 24'h00FF00; exp_grb[1] = 24'h00FF00;
    clear_mon();
    d0 = done_cnt_a;
    pulse_start(1'b0);
    s0 = start_cyc;
    while (cyc < s0 + 2000) tick();
    pulse_start(1'b0);
    while (cyc < s0 + 2 * PIX_CYC + 500) tick();
    pulse_start(1'b0);
    wait_done("ign", 1'b0, d0, 3500);
    check("ign_done_lat", done_cyc_a - s0, 2 * PIX_CYC + 3001);
    repeat (3500) tick();
    check("ign_done_cnt", done_cnt_a, d0 + 1);
    check("ign_idle", busy_a, 1'b0);
    check_frame("ign", 1'b0, 2);

    // 6. Reset at pixel 1, bit 5 (mid ring-high time), then a clean frame.
    clear_mon();
    d0 = done_cnt_a;
    pulse_start(1'b0);
    e = start_cyc + 2 + PIX_CYC + 5 * 63 + 10;
    while (cyc < e - 1) tick();
    check("abort_pre_low", led_a, 1'b0);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("abort_led", led_a, 1'b1);
    check("abort_busy", busy_a, 1'b1);
    wait_busy_low("abort", 3100, t);
    check("abort_busy_len", t - e, 3000);
    check("abort_no_done", done_cnt_a, d0);
    run_full("after_abort", 1'b0, 2);

    // 4. Read cadence and data on the 16-pixel ring.
    for (int i = 0; i < 16; i++) begin
      mem_b[i] = 24'(i * 24'h111111);
      exp_grb[i] = 24'(i * 24'h111111);
    end
    run_full("ring16", 1'b1, 16);
    check("ring16_rd_cnt", rd_cyc_b.size(), 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("ring16_rd_idx%0d", i), (i < rd_idx_b.size()) ? rd_idx_b[i] : -1, i);
    check("ring16_rd_first", (rd_cyc_b.size() > 0) ? rd_cyc_b[0] - start_cyc : -1, 0);
    check("ring16_rd_gap01", (rd_cyc_b.size() > 1) ? rd_cyc_b[1] - rd_cyc_b[0] : -1, 2);
    bad = 0;
    for (int i = 2; i < rd_cyc_b.size(); i++)
      if (rd_cyc_b[i] - rd_cyc_b[i-1] != PIX_CYC) bad++;
    check("ring16_rd_spacing", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
